// File: rtl/ifu_pkg.sv
// ifu_pkg - shared definitions for the instruction fetch unit.
//   ifu_state_e  : fetch sequencer states (3-bit encoding)
//   IFU_NOP      : word presented to the core when no valid instruction is held
//   IFU_RESET_PC : default fetch address after reset
//   ifu_fault_e  : fault cause encoding, reserved for a future mcause path
//   pc_aligned() : word-alignment test for fetch addresses
package ifu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } ifu_state_e;

  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_BUSERR   = 2'd2,
    FC_TIMEOUT  = 2'd3
  } ifu_fault_e;

  function automatic logic pc_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_wdog.sv
// ifu_wdog - response watchdog for the fetch unit.
// Counts enabled cycles from zero and saturates at TIMEOUT.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_clr     : synchronous clear to zero (wins over enable)
//   i_en      : count enable
//   o_expired : count has reached TIMEOUT
module ifu_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  assign o_expired = (r_cnt == W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch - instruction fetch unit feeding a single-cycle core.
// Fetches one word per instruction over a valid/ready request bus, presents it
// with o_inst_valid and waits for the core's commit + next PC.
//
//   state | meaning
//   IDLE  | after reset, start fetching next cycle
//   REQ   | request word at pc (or fault at once if pc is misaligned)
//   WAIT  | request accepted, waiting for response or timeout
//   HOLD  | cmd/pc presented to the core until commit or flush
//   DRAIN | redirected with a request in flight; swallow its response
//
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_commit, i_dnpc        : core consumed cmd; next PC (sampled in HOLD)
//   i_flush, i_flush_pc     : redirect, beats commit and same-cycle responses
//   o_pc, o_cmd             : PC and instruction word presented to the core
//   o_inst_valid            : cmd/pc valid
//   o_inst_fault            : fetch fault on o_pc, o_cmd is NOP
//   o_imem_req_valid/ready  : request handshake, o_imem_addr equals o_pc
//   i_imem_rsp_valid/data/err : single-cycle response pulse
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP      = IFU_NOP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_commit,
  input  logic [31:0] i_dnpc,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_cmd,
  output logic        o_inst_valid,
  output logic        o_inst_fault,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_imem_rsp_err
);

  ifu_state_e  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_cmd;
  logic        r_inst_valid;
  logic        r_inst_fault;
  logic        r_req_valid;

  logic        w_hs;
  logic        w_expired;
  logic        w_wd_clr;
  logic        w_pc_ok;
  logic        w_flush_pc_ok;
  logic        w_dnpc_ok;

  assign w_hs          = r_req_valid & i_imem_req_ready;
  assign w_pc_ok       = pc_aligned(r_pc);
  assign w_flush_pc_ok = pc_aligned(i_flush_pc);
  assign w_dnpc_ok     = pc_aligned(i_dnpc);

  // The watchdog runs only while a request is outstanding; a flush from WAIT
  // into DRAIN keeps the count so the total wait stays bounded.
  assign w_wd_clr = (r_state != ST_WAIT) && (r_state != ST_DRAIN);

  ifu_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_wd_clr),
    .i_en      (!w_wd_clr),
    .o_expired (w_expired)
  );

  // Request valid and inst valid are computed for the state being entered so
  // both leave the block as plain flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_cmd        <= NOP;
      r_inst_valid <= 1'b0;
      r_inst_fault <= 1'b0;
      r_req_valid  <= 1'b0;
    end else begin
      r_inst_valid <= 1'b0;
      r_req_valid  <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
          if (i_flush) begin
            r_pc         <= i_flush_pc;
            r_inst_fault <= 1'b0;
            r_req_valid  <= w_flush_pc_ok;
          end else begin
            r_req_valid  <= w_pc_ok;
          end
        end

        ST_REQ: begin
          if (i_flush) begin
            r_pc         <= i_flush_pc;
            r_inst_fault <= 1'b0;
            if (w_hs) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state     <= ST_REQ;
              r_req_valid <= w_flush_pc_ok;
            end
          end else if (!w_pc_ok) begin
            r_cmd        <= NOP;
            r_inst_fault <= 1'b1;
            r_state      <= ST_HOLD;
            r_inst_valid <= 1'b1;
          end else if (w_hs) begin
            r_state <= ST_WAIT;
          end else begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (i_flush) begin
            r_pc         <= i_flush_pc;
            r_inst_fault <= 1'b0;
            // A response in the flush cycle is the one we would drain: drop it.
            if (i_imem_rsp_valid) begin
              r_state     <= ST_REQ;
              r_req_valid <= w_flush_pc_ok;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (i_imem_rsp_valid) begin
            r_cmd        <= i_imem_rsp_err ? NOP : i_imem_rsp_data;
            r_inst_fault <= i_imem_rsp_err;
            r_state      <= ST_HOLD;
            r_inst_valid <= 1'b1;
          end else if (w_expired) begin
            r_cmd        <= NOP;
            r_inst_fault <= 1'b1;
            r_state      <= ST_HOLD;
            r_inst_valid <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_HOLD: begin
          if (i_flush) begin
            r_pc         <= i_flush_pc;
            r_inst_fault <= 1'b0;
            r_state      <= ST_REQ;
            r_req_valid  <= w_flush_pc_ok;
          end else if (i_commit) begin
            r_pc         <= i_dnpc;
            r_inst_fault <= 1'b0;
            r_state      <= ST_REQ;
            r_req_valid  <= w_dnpc_ok;
          end else begin
            r_state      <= ST_HOLD;
            r_inst_valid <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (i_flush) begin
            r_pc         <= i_flush_pc;
            r_inst_fault <= 1'b0;
          end
          // Leave once the stale response (or its timeout) is gone, even if
          // the core keeps redirecting; otherwise DRAIN would wait for a
          // response that was already swallowed.
          if (i_imem_rsp_valid || w_expired) begin
            r_state     <= ST_REQ;
            r_req_valid <= i_flush ? w_flush_pc_ok : w_pc_ok;
          end else begin
            r_state <= ST_DRAIN;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pc             = r_pc;
  assign o_imem_addr      = r_pc;
  assign o_cmd            = r_cmd;
  assign o_inst_valid     = r_inst_valid;
  assign o_inst_fault     = r_inst_fault;
  assign o_imem_req_valid = r_req_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch - self-checking bench for ifu_fetch (TIMEOUT = 4).
// Directed table of single fetches, hand-written redirect/reset sequences,
// then a randomized run checked against a transaction-level model.
module tb_ifu_fetch;

  localparam int          TO    = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam logic [31:0] NOPW  = 32'h0000_0013;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, commit, flush, ready, rsp_valid, rsp_err;
  logic [31:0] dnpc, flush_pc, rsp_data;
  logic [31:0] pc, cmd, addr;
  logic        iv, fault, req_valid;

  int n_chk  = 0;
  int n_pass = 0;
  int cur    = -1;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC (RPC),
    .TIMEOUT  (TO),
    .NOP      (NOPW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_commit         (commit),
    .i_dnpc           (dnpc),
    .i_flush          (flush),
    .i_flush_pc       (flush_pc),
    .o_pc             (pc),
    .o_cmd            (cmd),
    .o_inst_valid     (iv),
    .o_inst_fault     (fault),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (ready),
    .o_imem_addr      (addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_imem_rsp_err   (rsp_err)
  );

  typedef struct {
    logic [31:0] pc;
    int          rdy_wait;
    int          rsp_dly;
    logic        err;
    logic        never;
    logic [31:0] data;
    logic [31:0] exp_cmd;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %08h expected %08h", name, cur, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_pc(input int k);
    logic [31:0] p;
    p = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
    if ($urandom_range(0, k - 1) == 0) p[1:0] = 2'($urandom_range(1, 3));
    return p;
  endfunction

  function automatic vec_t mk(input logic [31:0] p, input int rw, input int dly,
                              input logic e, input logic nv, input logic [31:0] d,
                              input logic [31:0] ec, input logic ef, input int el);
    vec_t v;
    v.pc = p; v.rdy_wait = rw; v.rsp_dly = dly; v.err = e; v.never = nv; v.data = d;
    v.exp_cmd = ec; v.exp_fault = ef; v.exp_lat = el;
    return v;
  endfunction

  // Core side: DUT is in HOLD at this negedge; commit moves it to REQ.
  task automatic do_commit(input logic [31:0] npc);
    commit = 1'b1;
    dnpc   = npc;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Starts at the negedge of the REQ cycle; lat counts cycles from the
  // handshake (or from the REQ cycle for a misaligned pc) to inst_valid.
  task automatic fetch_one(input vec_t v);
    int   lat;
    logic ok;
    ok = (v.pc[1:0] == 2'b00);
    chk("req_iv_low", iv, 0);
    chk("req_fault_low", fault, 0);
    chk("req_valid", req_valid, ok);
    chk("req_addr", addr, v.pc);
    if (ok) begin
      for (int i = 0; i < v.rdy_wait; i++) begin
        ready     = 1'b0;
        rsp_valid = (i == 0);
        rsp_data  = STALE;
        rsp_err   = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("stall_req_valid", req_valid, 1);
        chk("stall_addr", addr, v.pc);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      lat   = 1;
      while (!iv && lat < 20) begin
        rsp_valid = !v.never && (lat - 1 == v.rsp_dly);
        rsp_data  = v.data;
        rsp_err   = v.err;
        @(negedge clk);
        lat++;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
      end
    end else begin
      @(negedge clk);
      lat = 1;
      while (!iv && lat < 20) begin
        @(negedge clk);
        lat++;
      end
    end
    chk("latency", lat, v.exp_lat);
    chk("inst_valid", iv, 1);
    chk("cmd", cmd, v.exp_cmd);
    chk("inst_fault", fault, v.exp_fault);
    chk("pc", pc, v.pc);
  endtask

  // Randomized-phase model state
  logic [31:0] exp_pc, res_cmd, pdata;
  logic        res_fault, hs_ok, pend, pnever, perr, hs;
  int          pcnt, npres;

  initial begin
    rst = 1'b1; commit = 1'b0; flush = 1'b0; ready = 1'b0;
    rsp_valid = 1'b0; rsp_err = 1'b0; dnpc = '0; flush_pc = '0; rsp_data = '0;

    tbl[0] = mk(32'h8000_0004, 0, 0, 0, 0, 32'h0020_0113, 32'h0020_0113, 0, 2);
    tbl[1] = mk(32'h8000_0008, 5, 1, 0, 0, 32'h0030_8193, 32'h0030_8193, 0, 3);
    tbl[2] = mk(32'h8000_0002, 0, 0, 0, 0, 32'h0000_0000, NOPW,          1, 1);
    tbl[3] = mk(32'h8000_000C, 0, 0, 1, 0, 32'hCAFE_F00D, NOPW,          1, 2);
    tbl[4] = mk(32'h8000_0010, 2, 0, 0, 1, 32'h0000_0000, NOPW,          1, TO + 2);
    tbl[5] = mk(32'h8000_0014, 0, TO, 0, 0, 32'h00A0_0513, 32'h00A0_0513, 0, TO + 2);
    tbl[6] = mk(32'h8000_0018, 0, 3, 0, 0, 32'h1234_5678, 32'h1234_5678, 0, 5);
    tbl[7] = mk(32'h8000_0003, 0, 0, 0, 0, 32'h0000_0000, NOPW,          1, 1);
    tbl[8] = mk(32'h8000_001C, 1, 2, 1, 0, 32'h0040_0213, NOPW,          1, 4);

    // Reset values; a flush during reset must not move pc.
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_cmd", cmd, NOPW);
    chk("rst_iv", iv, 0);
    chk("rst_fault", fault, 0);
    chk("rst_req_valid", req_valid, 0);
    flush = 1'b1; flush_pc = 32'h1234_0000;
    @(negedge clk);
    flush = 1'b0;
    chk("rst_flush_ignored", pc, RPC);
    rst = 1'b0;
    @(negedge clk);

    // First fetch from the reset PC, minimum latency.
    fetch_one(mk(RPC, 0, 0, 0, 0, 32'h0010_0093, 32'h0010_0093, 0, 2));

    for (int i = 0; i < 9; i++) begin
      cur = i;
      do_commit(tbl[i].pc);
      fetch_one(tbl[i]);
    end

    // Flush in WAIT, stale response later during DRAIN.
    cur = 100;
    do_commit(32'h8000_0040);
    ready = 1'b1; @(negedge clk); ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h8000_0100;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_pc", pc, 32'h8000_0100);
    chk("drain_iv", iv, 0);
    chk("drain_no_req", req_valid, 0);
    rsp_valid = 1'b1; rsp_data = STALE;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("drain_cmd_kept", cmd, tbl[8].exp_cmd);
    fetch_one(mk(32'h8000_0100, 0, 0, 0, 0, 32'h0050_0293, 32'h0050_0293, 0, 2));

    // Flush and response in the same WAIT cycle: response dropped, refetch.
    cur = 101;
    do_commit(32'h8000_0200);
    ready = 1'b1; @(negedge clk); ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h8000_0300; rsp_valid = 1'b1; rsp_data = STALE;
    @(negedge clk);
    flush = 1'b0; rsp_valid = 1'b0;
    fetch_one(mk(32'h8000_0300, 0, 1, 0, 0, 32'h0060_0313, 32'h0060_0313, 0, 3));

    // Flush beats commit in HOLD.
    cur = 102;
    commit = 1'b1; dnpc = 32'h8000_0400; flush = 1'b1; flush_pc = 32'h8000_0500;
    @(negedge clk);
    commit = 1'b0; flush = 1'b0;
    fetch_one(mk(32'h8000_0500, 0, 0, 0, 0, 32'h0070_0393, 32'h0070_0393, 0, 2));

    // Reset while WAIT, response two cycles later must be ignored.
    cur = 103;
    do_commit(32'h8000_0600);
    ready = 1'b1; @(negedge clk); ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_pc", pc, RPC);
    chk("rstw_cmd", cmd, NOPW);
    chk("rstw_iv", iv, 0);
    chk("rstw_req", req_valid, 0);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_data = STALE;
    @(negedge clk);
    rsp_valid = 1'b0;
    fetch_one(mk(RPC, 0, 0, 0, 0, 32'h0080_0413, 32'h0080_0413, 0, 2));

    // Randomized run against a transaction-level model.
    cur = 200;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = RPC; pend = 1'b0; hs_ok = 1'b0; npres = 0; pcnt = 0;
    pnever = 1'b0; perr = 1'b0; pdata = '0; res_cmd = NOPW; res_fault = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_pc", pc, exp_pc);
      chk("rnd_addr", addr, exp_pc);
      if (req_valid) chk("rnd_req_aligned", {30'd0, addr[1:0]}, 0);
      if (iv) begin
        npres++;
        if (exp_pc[1:0] != 2'b00) begin
          chk("rnd_mis_cmd", cmd, NOPW);
          chk("rnd_mis_fault", fault, 1);
        end else begin
          chk("rnd_fetched", hs_ok, 1);
          chk("rnd_cmd", cmd, res_cmd);
          chk("rnd_fault", fault, res_fault);
        end
      end else begin
        chk("rnd_fault_without_valid", fault, 0);
      end

      flush    = ($urandom_range(0, 11) == 0);
      flush_pc = rand_pc(6);
      commit   = ($urandom_range(0, 2) == 0);
      dnpc     = rand_pc(8);
      ready    = 1'($urandom_range(0, 1));
      rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = STALE;
      if (pend) begin
        if (pcnt == 0) begin
          pend = 1'b0;
          if (!pnever) begin
            rsp_valid = 1'b1; rsp_data = pdata; rsp_err = perr;
          end
        end else begin
          pcnt--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        rsp_valid = 1'b1;
        rsp_err   = 1'($urandom_range(0, 1));
      end

      hs = req_valid && ready;
      if (hs) begin
        chk("rnd_one_outstanding", pend, 0);
        pend      = 1'b1;
        pcnt      = $urandom_range(0, TO);
        pnever    = ($urandom_range(0, 7) == 0);
        perr      = ($urandom_range(0, 7) == 0);
        pdata     = mem_word(addr);
        res_fault = pnever || perr;
        res_cmd   = res_fault ? NOPW : pdata;
        hs_ok     = 1'b1;
      end
      if (flush) begin
        exp_pc = flush_pc;
        hs_ok  = 1'b0;
      end else if (commit && iv) begin
        exp_pc = dnpc;
        hs_ok  = 1'b0;
      end
      @(negedge clk);
    end
    flush = 1'b0; commit = 1'b0; ready = 1'b0; rsp_valid = 1'b0;
    chk("rnd_enough_presentations", (npres > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
